adam_axil_mem_resp: RTL and testbench
=====================================

# adam_axil_mem_resp

AXI-Lite responder that terminates one fabric master port (a `mem` or `hsp` leg of the high-speed-domain crossbar) and drives a single-port, synchronous-read memory macro. It serializes write and read transactions one at a time, applies byte strobes, returns B/R responses, and honours the ADAM pause protocol so the domain can be quiesced between transactions. Addresses arrive already offset to zero by the fabric.

## Interface

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width
- DATA_WIDTH, 32, AXI-Lite data width (32 or 64)
- SIZE, 4096, memory size in bytes; power of two, at least DATA_WIDTH/8
- STRB_WIDTH, DATA_WIDTH/8, derived
- MEM_AW, $clog2(SIZE/STRB_WIDTH), derived word-address width

Ports:
- seq.clk  in  1  clock (ADAM_SEQ slave)
- seq.rst  in  1  reset, synchronous, active-high
- pause.req  in  1  pause request (ADAM_PAUSE slave)
- pause.ack  out  1  pause acknowledge
- slv  AXI_LITE slave  ADDR_WIDTH/DATA_WIDTH  AW/W/B/AR/R channels from the fabric
- mem_req  out  1  memory access strobe
- mem_we  out  1  write enable (qualified by mem_req)
- mem_addr  out  MEM_AW  word address = addr[MEM_AW+log2(STRB_WIDTH)-1 : log2(STRB_WIDTH)]
- mem_be  out  STRB_WIDTH  byte enables = wstrb for writes, all-ones for reads
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after a read mem_req

## Operation

- States: PAUSED, IDLE, RD_WAIT, RD_RESP, WR_RESP.
- Reset: state PAUSED; pause.ack=1; awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; mem_req=0; priority=read.
- PAUSED: all ready signals low, ack=1. When pause.req=0, go to IDLE and deassert ack.
- IDLE: if pause.req=1, go to PAUSED (ack rises the next cycle). Otherwise a write is eligible when awvalid and wvalid are both high; a read is eligible when arvalid is high.
- Arbitration: if both are eligible, serve the side opposite the last-served side; the priority bit flips after every accepted transaction.
- Write accept: awready=wready=1 in the same cycle, mem_req=1, mem_we=1; go to WR_RESP with bvalid=1 and bresp=OKAY. Hold bvalid until bready, then go to IDLE.
- Read accept: arready=1, mem_req=1, mem_we=0; go to RD_WAIT, capture mem_rdata into rdata, then go to RD_RESP with rvalid=1 and rresp=OKAY. Hold rvalid and rdata stable until rready, then go to IDLE.
- Pause is never acknowledged with a response outstanding; a request arriving mid-transaction takes effect on return to IDLE.
- Address bits above the word index and below the byte offset are ignored, subject to Configuration.
- awprot and arprot are ignored.

## Timing

- Write: accept at cycle N, bvalid at N+1. Minimum 2 cycles per write with bready tied high.
- Read: accept at N, mem_rdata sampled at N+1, rvalid at N+2. Minimum 3 cycles per read.
- Ready signals are driven combinationally from state and valids, only in IDLE. At most one mem_req is issued per transaction.
- A reset asserted mid-transaction abandons the transaction with no response; outputs return to reset values on the next edge.

## Configuration

- ADAM_AXIL_MEM_RESP_ERR_EN defined: any address with nonzero bits at or above log2(SIZE) is accepted normally but issues no mem_req. Writes respond with bresp=SLVERR; reads respond with rresp=SLVERR and rdata=0. Timing is identical to an in-range access.
- Not defined: out-of-range addresses alias modulo SIZE and always respond OKAY.

## Structure

- Package adam_axil_mem_resp_pkg holds state_t (PAUSED, IDLE, RD_WAIT, RD_RESP, WR_RESP) and the AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- The design is a single module with no sub-module. The memory macro is external; the bench uses a behavioural 1-cycle-latency RAM.

## Test plan

- Reset with pause.req=1, then drop req → ack=1 during reset/pause, ack=0 one cycle after req falls, no readies while paused.
- Write 0xDEADBEEF to 0x10 with wstrb=4'b0101, then read 0x10 → bvalid at N+1 with OKAY; read returns 0x00AD00EF over zero-initialized memory, rvalid at N+2.
- AW, W and AR all valid and held for 4 transactions → served alternately, read first after reset; each mem_req is single-cycle.
- rready held low for 5 cycles → rvalid and rdata stable, arready stays 0, no extra mem_req.
- pause.req asserted during WR_RESP with bready low → ack stays 0 until the B handshake completes, then rises.
- With ERR_EN, SIZE=4096, read 0x1000 and write 0x2004 → SLVERR on both, rdata=0, no mem_req. Without ERR_EN, 0x1000 aliases word 0.

Source files
------------

// File: rtl/adam_axil_mem_resp_pkg.sv
// Shared types for the AXI-Lite memory responder: FSM state encoding and AXI response codes.
package adam_axil_mem_resp_pkg;

    typedef enum logic [2:0] {
        PAUSED  = 3'd0,
        IDLE    = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/adam_axil_mem_resp.sv
// AXI-Lite responder driving a single-port synchronous-read memory, one transaction at a time.
// Define ADAM_AXIL_MEM_RESP_ERR_EN to answer out-of-range addresses with SLVERR instead of aliasing.
module adam_axil_mem_resp
    import adam_axil_mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SIZE       = 4096,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned MEM_AW     = $clog2(SIZE / STRB_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    pause_req,
    output logic                    pause_ack,

    input  logic [ADDR_WIDTH-1:0]   slv_awaddr,
    input  logic [2:0]              slv_awprot,
    input  logic                    slv_awvalid,
    output logic                    slv_awready,
    input  logic [DATA_WIDTH-1:0]   slv_wdata,
    input  logic [STRB_WIDTH-1:0]   slv_wstrb,
    input  logic                    slv_wvalid,
    output logic                    slv_wready,
    output logic [1:0]              slv_bresp,
    output logic                    slv_bvalid,
    input  logic                    slv_bready,
    input  logic [ADDR_WIDTH-1:0]   slv_araddr,
    input  logic [2:0]              slv_arprot,
    input  logic                    slv_arvalid,
    output logic                    slv_arready,
    output logic [DATA_WIDTH-1:0]   slv_rdata,
    output logic [1:0]              slv_rresp,
    output logic                    slv_rvalid,
    input  logic                    slv_rready,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [STRB_WIDTH-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned OFF = $clog2(STRB_WIDTH);

    state_t                 state_q, state_d;
    logic                   prio_wr_q, prio_wr_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   rd_err_q, rd_err_d;

    logic wr_elig, rd_elig;
    logic do_wr, do_rd;
    logic wr_oor, rd_oor;

`ifdef ADAM_AXIL_MEM_RESP_ERR_EN
    localparam int unsigned SIZE_AW = $clog2(SIZE);
    assign wr_oor = (slv_awaddr >> SIZE_AW) != '0;
    assign rd_oor = (slv_araddr >> SIZE_AW) != '0;
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    // Protection bits and address bits outside the word index carry no meaning here.
    logic unused_sigs;
    assign unused_sigs = ^{slv_awprot, slv_arprot, slv_awaddr, slv_araddr};

    assign wr_elig = slv_awvalid & slv_wvalid;
    assign rd_elig = slv_arvalid;

    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        bresp_d   = bresp_q;
        rd_err_d  = rd_err_q;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        unique case (state_q)
            PAUSED: begin
                if (!pause_req) state_d = IDLE;
            end
            IDLE: begin
                if (pause_req) begin
                    state_d = PAUSED;
                end else if (wr_elig && (!rd_elig || prio_wr_q)) begin
                    do_wr     = 1'b1;
                    bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
                    prio_wr_d = 1'b0;
                    state_d   = WR_RESP;
                end else if (rd_elig) begin
                    do_rd     = 1'b1;
                    rd_err_d  = rd_oor;
                    prio_wr_d = 1'b1;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rdata_d = rd_err_q ? '0 : mem_rdata;
                rresp_d = rd_err_q ? RESP_SLVERR : RESP_OKAY;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (slv_rready) state_d = IDLE;
            end
            WR_RESP: begin
                if (slv_bready) state_d = IDLE;
            end
            default: state_d = PAUSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PAUSED;
            prio_wr_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign pause_ack   = (state_q == PAUSED);
    assign slv_awready = do_wr;
    assign slv_wready  = do_wr;
    assign slv_arready = do_rd;
    assign slv_bvalid  = (state_q == WR_RESP);
    assign slv_bresp   = bresp_q;
    assign slv_rvalid  = (state_q == RD_RESP);
    assign slv_rdata   = rdata_q;
    assign slv_rresp   = rresp_q;

    // Out-of-range accesses still handshake but never touch the macro.
    assign mem_req   = (do_wr & ~wr_oor) | (do_rd & ~rd_oor);
    assign mem_we    = do_wr;
    assign mem_addr  = do_wr ? slv_awaddr[MEM_AW+OFF-1:OFF] : slv_araddr[MEM_AW+OFF-1:OFF];
    assign mem_be    = do_wr ? slv_wstrb : '1;
    assign mem_wdata = slv_wdata;

endmodule

// File: tb/tb_adam_axil_mem_resp.sv
// Scoreboard bench for adam_axil_mem_resp: byte-array reference memory, randomized traffic.
module tb_adam_axil_mem_resp;
    import adam_axil_mem_resp_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SIZE = 4096;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned MAW  = $clog2(SIZE / SW);

    logic clk = 1'b0;
    logic rst;
    logic pause_req, pause_ack;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0] bresp, rresp;
    logic mem_req, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [SW-1:0] mem_be;
    logic [DW-1:0] mem_wdata, mem_rdata;

    adam_axil_mem_resp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE(SIZE)
    ) dut (
        .clk(clk), .rst(rst),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .slv_awaddr(awaddr), .slv_awprot(awprot), .slv_awvalid(awvalid), .slv_awready(awready),
        .slv_wdata(wdata), .slv_wstrb(wstrb), .slv_wvalid(wvalid), .slv_wready(wready),
        .slv_bresp(bresp), .slv_bvalid(bvalid), .slv_bready(bready),
        .slv_araddr(araddr), .slv_arprot(arprot), .slv_arvalid(arvalid), .slv_arready(arready),
        .slv_rdata(rdata), .slv_rresp(rresp), .slv_rvalid(rvalid), .slv_rready(rready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 1-cycle-latency RAM standing in for the macro.
    logic [DW-1:0] ram [SIZE/SW];
    initial for (int i = 0; i < int'(SIZE / SW); i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_req && mem_we) begin
            for (int i = 0; i < int'(SW); i++)
                if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end else if (mem_req) begin
            mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model: flat byte array, addresses reduced modulo SIZE.
    logic [7:0] ref_mem [SIZE];
    initial for (int i = 0; i < int'(SIZE); i++) ref_mem[i] = 8'h00;

    function automatic bit is_oor(input logic [AW-1:0] a);
`ifdef ADAM_AXIL_MEM_RESP_ERR_EN
        return a >= SIZE;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_base(input logic [AW-1:0] a);
        int b;
        b = int'(a % SIZE);
        return b - (b % int'(SW));
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        int b;
        b = word_base(a);
        for (int i = 0; i < int'(SW); i++) d[8*i +: 8] = ref_mem[b + i];
        return d;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s);
        int b;
        b = word_base(a);
        for (int i = 0; i < int'(SW); i++)
            if (s[i]) ref_mem[b + i] = d[8*i +: 8];
    endtask

    typedef struct { logic [DW-1:0] data; logic [1:0] resp; } rexp_t;
    logic [1:0] exp_b [$];
    rexp_t      exp_r [$];
    byte        served [$];

    int n_cmp = 0, n_fail = 0;
    int exp_memreq = 0, act_memreq = 0;
    int acc_cyc = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected event (cycle %0d)", name, cyc);
    endtask

    // Acceptance monitor: predicts the response at the moment a request handshakes.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (awvalid && wvalid && awready && wready) begin
                exp_b.push_back(is_oor(awaddr) ? RESP_SLVERR : RESP_OKAY);
                if (!is_oor(awaddr)) begin
                    model_write(awaddr, wdata, wstrb);
                    exp_memreq++;
                end
                served.push_back("W");
                acc_cyc = cyc;
            end
            if (arvalid && arready) begin
                if (is_oor(araddr)) exp_r.push_back('{data: '0, resp: RESP_SLVERR});
                else begin
                    exp_r.push_back('{data: model_read(araddr), resp: RESP_OKAY});
                    exp_memreq++;
                end
                served.push_back("R");
                acc_cyc = cyc;
            end
            if (mem_req) act_memreq++;
        end
    end

    // Response checker: pops the scoreboard on every B/R handshake.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) fail_now("b_unexpected");
                else check("bresp", bresp, exp_b.pop_front());
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) fail_now("r_unexpected");
                else begin
                    rexp_t e;
                    e = exp_r.pop_front();
                    check("rdata", rdata, e.data);
                    check("rresp", rresp, e.resp);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) begin
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s);
        bit got;
        awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
        awvalid = 1'b1; wvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = awready && wready;
            step();
        end
        if (!got) fail_now("write_accept");
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic drive_read(input logic [AW-1:0] a);
        bit got;
        araddr = a; arprot = 3'($urandom);
        arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = arready;
            step();
        end
        if (!got) fail_now("read_accept");
        arvalid = 1'b0;
    endtask

    task automatic wait_valid(input bit is_r, output int at);
        at = -1;
        for (int i = 0; i < 30 && at < 0; i++) begin
            @(negedge clk);
            if (is_r ? rvalid : bvalid) at = cyc;
        end
        step();
    endtask

    initial begin
        int at, mr0;
        bit seen;
        rst = 1'b1; pause_req = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", pause_ack, 1);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {bresp, rresp}, 0);
        check("rst_mem_req", mem_req, 0);
        step();
        rst = 1'b0;

        // All three channels valid while paused, then released: expect R,W,R,W.
        awaddr = 32'h40; wdata = 32'h1122_3344; wstrb = 4'hf; araddr = 32'h40;
        awvalid = 1; wvalid = 1; arvalid = 1;
        step();
        @(negedge clk);
        check("paused_arready", arready, 0);
        check("paused_awready", awready, 0);
        check("paused_ack", pause_ack, 1);
        step();
        pause_req = 1'b0;
        @(negedge clk);
        check("ack_before_release", pause_ack, 1);
        step();
        @(negedge clk);
        check("ack_after_release", pause_ack, 0);
        for (int i = 0; i < 40 && served.size() < 4; i++) step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        if (served.size() < 4) fail_now("alternation");
        else for (int i = 0; i < 4; i++) check("alt_order", served[i], (i % 2 == 0) ? "R" : "W");
        repeat (3) step();

        // Strobed write then read-back, with latency checks.
        drive_write(32'h10, 32'hDEAD_BEEF, 4'b0101);
        wait_valid(1'b0, at);
        check("b_latency", at, acc_cyc + 1);
        drive_read(32'h10);
        wait_valid(1'b1, at);
        check("r_latency", at, acc_cyc + 2);
        check("strobed_rdata", rdata, 32'h00AD_00EF);

        // R channel back-pressure with another read pending.
        rready = 1'b0;
        drive_read(32'h10);
        araddr = 32'h40; arvalid = 1'b1;
        wait_valid(1'b1, at);
        mr0 = act_memreq;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rvalid", rvalid, 1);
            if (exp_r.size() > 0) check("hold_rdata", rdata, exp_r[0].data);
            check("hold_arready", arready, 0);
            step();
        end
        check("hold_no_memreq", act_memreq, mr0);
        rready = 1'b1;
        drive_read(32'h40);
        repeat (4) step();

        // Pause request during an outstanding write response.
        bready = 1'b0;
        drive_write(32'h14, $urandom, 4'hf);
        pause_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wr_resp_ack", pause_ack, 0);
            check("wr_resp_bvalid", bvalid, 1);
            step();
        end
        bready = 1'b1;
        @(negedge clk);
        check("ack_at_b_hs", pause_ack, 0);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = pause_ack;
        end
        check("ack_after_b_hs", seen, 1);
        step();
        pause_req = 1'b0;
        repeat (3) step();

        // Out-of-range addresses: SLVERR without a memory access, or aliasing.
        mr0 = act_memreq;
        drive_write(32'h2004, 32'hCAFE_F00D, 4'hf);
        repeat (2) step();
        drive_read(32'h1000);
        repeat (3) step();
        drive_read(32'h4);
        repeat (3) step();
`ifdef ADAM_AXIL_MEM_RESP_ERR_EN
        check("oor_memreq", act_memreq - mr0, 1);
`else
        check("alias_memreq", act_memreq - mr0, 3);
`endif

        // Randomized traffic with random B/R back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 2 * SIZE - 1));
            if ($urandom_range(0, 1) == 1) drive_write(a, $urandom, SW'($urandom));
            else drive_read(a);
        end
        rand_ready = 1'b0;
        bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 50 && (exp_b.size() + exp_r.size()) != 0; i++) step();
        if ((exp_b.size() + exp_r.size()) != 0) fail_now("drain");
        repeat (2) step();
        check("memreq_total", act_memreq, exp_memreq);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
